// File: rtl/tg_axi_lite_master.sv
// tg_axi_lite_master: single-outstanding AXI4-Lite master driven by one-cycle wr_req/rd_req pulses.
// Every output is a flop, so there are no combinational paths from AXI inputs to AXI outputs.
module tg_axi_lite_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                        m_axi_aclk,
    input  logic                        m_axi_areset,
    input  logic                        wr_req,
    input  logic                        rd_req,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                        op_ack,
    output logic [AXI_DATA_WIDTH-1:0]   rdata,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, ACK} state_t;
    state_t                      state_q;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, op_ack_q;
    logic                        unused_resp;
    assign unused_resp   = ^{m_axi_bresp, m_axi_rresp};
    assign op_ack        = op_ack_q;
    assign rdata         = rdata_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            op_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_req) begin
                        awaddr_q  <= addr;
                        wdata_q   <= wdata;
                        wstrb_q   <= wstrb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= WR_AW_W;
                    end else if (rd_req) begin
                        araddr_q  <= addr;
                        arvalid_q <= 1'b1;
                        state_q   <= RD_AR;
                    end
                end
                WR_AW_W: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready) wvalid_q <= 1'b0;
                    // Advance once each channel has either already handshaken or does so now
                    if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        op_ack_q <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                RD_AR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid) begin
                        rdata_q  <= m_axi_rdata;
                        rready_q <= 1'b0;
                        op_ack_q <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    op_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tg_axi_lite_master.sv
// tb_tg_axi_lite_master: randomized AXI4-Lite slave plus word-array reference model and op_ack scoreboard.
module tb_tg_axi_lite_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        op_ack;
    logic [31:0] rdata, awaddr, wd, araddr;
    logic [3:0]  ws;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [31:0] rdata_s = '0;

    tg_axi_lite_master dut (
        .m_axi_aclk(clk), .m_axi_areset(rst), .wr_req(wr_req), .rd_req(rd_req),
        .addr(addr), .wdata(wdata), .wstrb(wstrb), .op_ack(op_ack), .rdata(rdata),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wd), .m_axi_wstrb(ws), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(2'b00), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata_s), .m_axi_rresp(2'b00), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0, ack_cnt = 0, acks_exp = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [31:0] exp_aw[$], exp_ar[$];
    logic [35:0] exp_w[$];
    logic [32:0] exp_ack[$];
    logic [31:0] mmem[16];
    logic [31:0] smem[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: handshakes seen at a rising edge are reconstructed from the previous falling-edge sample
    logic        p_awv, p_wv, p_bv, p_br, p_arv, p_rv, p_rr, got_aw, got_w, b_pend, r_pend;
    logic [31:0] p_awaddr, p_wdata, p_araddr, aw_lat, ar_lat;
    logic [3:0]  p_wstrb;
    logic [35:0] w_lat;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            p_awv = 0; p_wv = 0; p_bv = 0; p_br = 0; p_arv = 0; p_rv = 0; p_rr = 0;
        end else begin
            if (p_awv && !awready) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !wready) chk("w_stable", {wvalid, ws, wd}, {1'b1, p_wstrb, p_wdata});
            if (p_arv && !arready) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
            if (p_awv && awready) begin
                chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
                if (exp_aw.size() != 0) chk("awaddr", p_awaddr, exp_aw.pop_front());
                aw_lat = p_awaddr; got_aw = 1;
            end
            if (p_wv && wready) begin
                chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
                if (exp_w.size() != 0) chk("wdata_wstrb", {p_wstrb, p_wdata}, exp_w.pop_front());
                w_lat = {p_wstrb, p_wdata}; got_w = 1;
            end
            if (p_bv && p_br) bvalid = 0;
            if (got_aw && got_w) begin
                for (int b = 0; b < 4; b++)
                    if (w_lat[32+b]) smem[aw_lat[5:2]][8*b +: 8] = w_lat[8*b +: 8];
                got_aw = 0; got_w = 0; b_pend = 1; b_cnt = b_dly;
            end
            if (b_pend) begin
                if (b_cnt == 0) begin bvalid = 1; b_pend = 0; end else b_cnt--;
            end
            if (bready) chk("bready_after_aw_w", {awvalid, wvalid}, 2'b00);
            if (p_arv && arready) begin
                chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
                if (exp_ar.size() != 0) chk("araddr", p_araddr, exp_ar.pop_front());
                ar_lat = p_araddr; r_pend = 1; r_cnt = r_dly;
            end
            if (p_rv && p_rr) rvalid = 0;
            if (r_pend) begin
                if (r_cnt == 0) begin rvalid = 1; rdata_s = smem[ar_lat[5:2]]; r_pend = 0; end else r_cnt--;
            end
            if (!awvalid) aw_cnt = aw_dly;
            if (!wvalid) w_cnt = w_dly;
            if (!arvalid) ar_cnt = ar_dly;
            awready = awvalid && aw_cnt == 0;
            wready  = wvalid && w_cnt == 0;
            arready = arvalid && ar_cnt == 0;
            if (awvalid && aw_cnt != 0) aw_cnt--;
            if (wvalid && w_cnt != 0) w_cnt--;
            if (arvalid && ar_cnt != 0) ar_cnt--;
            p_awv = awvalid; p_awaddr = awaddr; p_wv = wvalid; p_wdata = wd; p_wstrb = ws;
            p_bv = bvalid; p_br = bready; p_arv = arvalid; p_araddr = araddr; p_rv = rvalid; p_rr = rready;
        end
    end

    // Monitor: every op_ack pops one expected completion; rdata must otherwise hold
    logic [31:0] last_rd;
    logic [32:0] e;
    always @(negedge clk) begin
        if (rst) last_rd = '0;
        else if (op_ack) begin
            ack_cnt++;
            chk("ack_expected", 64'(exp_ack.size() != 0), 64'd1);
            if (exp_ack.size() != 0) begin
                e = exp_ack.pop_front();
                if (e[32]) last_rd = e[31:0];
                chk(e[32] ? "rdata_on_ack" : "rdata_on_wr_ack", rdata, last_rd);
            end
        end else if (p_rv || rvalid || vectors % 7 == 0) chk("rdata_hold", rdata, last_rd);
    end

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) mmem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_aw.push_back(a);
        exp_w.push_back({s, d});
        exp_ack.push_back({1'b0, 32'h0});
        acks_exp++;
        model_wr(a, d, s);
        @(negedge clk);
        wr_req = 1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        wr_req = 0; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    endtask

    task automatic issue_rd(input logic [31:0] a);
        exp_ar.push_back(a);
        exp_ack.push_back({1'b1, mmem[a[5:2]]});
        acks_exp++;
        @(negedge clk);
        rd_req = 1; addr = a;
        @(negedge clk);
        rd_req = 0; addr = $urandom;
    endtask

    task automatic wait_acks();
        for (int i = 0; i < 300 && ack_cnt < acks_exp; i++) @(posedge clk);
        chk("ack_timeout", 64'(ack_cnt), 64'(acks_exp));
        acks_exp = ack_cnt;
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mmem[i] = '0; smem[i] = '0; end
        wr_req = 1; addr = 32'h4; wdata = 32'h1; wstrb = 4'hF;
        @(negedge clk);
        wr_req = 0;
        repeat (2) @(negedge clk);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, op_ack}, 6'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addrs", {awaddr, araddr}, 64'h0);
        chk("rst_wdata_wstrb", {ws, wd}, 36'h0);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("no_req_after_rst", {awvalid, arvalid, op_ack}, 3'b0);

        set_dly(0, 0, 0, 0, 0);
        issue_wr(32'h04, 32'h1, 4'hF);
        wait_acks();
        chk("write_model", smem[1], 32'h1);

        issue_wr(32'h20, 32'hDEADBEEF, 4'hF);
        wait_acks();
        set_dly(0, 0, 0, 3, 2);
        issue_rd(32'h20);
        wait_acks();
        repeat (4) @(negedge clk);
        chk("rdata_held", rdata, 32'hDEADBEEF);

        set_dly(5, 0, 0, 0, 0);
        issue_wr(32'h10, 32'h1234_5678, 4'h5);
        repeat (3) @(negedge clk);
        chk("skew_aw_holds_w_done", {awvalid, wvalid, bready}, 3'b100);
        wait_acks();

        set_dly(0, 0, 0, 0, 0);
        exp_aw.push_back(32'h0C);
        exp_w.push_back({4'hF, 32'hCAFE_0001});
        exp_ack.push_back({1'b0, 32'h0});
        acks_exp++;
        model_wr(32'h0C, 32'hCAFE_0001, 4'hF);
        @(negedge clk);
        wr_req = 1; rd_req = 1; addr = 32'h0C; wdata = 32'hCAFE_0001; wstrb = 4'hF;
        @(negedge clk);
        wr_req = 0; rd_req = 0;
        wait_acks();

        set_dly(5, 2, 1, 0, 0);
        issue_wr(32'h18, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        rd_req = 1; addr = 32'h3C;
        @(negedge clk);
        rd_req = 0;
        wait_acks();

        set_dly(20, 20, 0, 0, 0);
        @(negedge clk);
        wr_req = 1; addr = 32'h08; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        @(negedge clk);
        wr_req = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_valids", {awvalid, wvalid, bready, op_ack}, 4'b0);
        rst = 0;
        repeat (6) @(negedge clk);
        chk("abort_no_ack", 64'(ack_cnt), 64'(acks_exp));

        set_dly(0, 0, 0, 0, 0);
        issue_wr(32'h04, 32'h0001, 4'hF);  wait_acks(); repeat (5) @(negedge clk);
        issue_wr(32'h08, 32'h00AA, 4'hF);  wait_acks(); repeat (5) @(negedge clk);
        issue_wr(32'h00, 32'h0042, 4'hF);  wait_acks(); repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue_rd(32'h00); wait_acks(); repeat (5) @(negedge clk);
        end

        for (int i = 0; i < 80; i++) begin
            set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 4), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) issue_wr({26'h0, 4'($urandom), 2'b00}, $urandom, 4'($urandom));
            else issue_rd({26'h0, 4'($urandom), 2'b00});
            wait_acks();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_ack.size()), 64'd0);
        for (int i = 0; i < 16; i++) chk("final_mem", smem[i], mmem[i]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
